// File: rtl/sensor_hub.sv
// Multi-channel front-end for 40-bit DHT11-style sensor drivers: decodes one host
// request at a time and services per-channel continuous modes from a shared period tick.
module sensor_hub #(
  parameter int NUM_SENSORS        = 4,
  parameter int LOOP_PERIOD_CYCLES = 125000000,
  parameter int TIMEOUT_CYCLES     = 5000000
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic                      enable_i,
  input  logic [7:0]                request_command_i,
  input  logic [7:0]                request_address_i,
  output logic [NUM_SENSORS-1:0]    sensor_enable_o,
  input  logic [40*NUM_SENSORS-1:0] sensor_data_i,
  input  logic [NUM_SENSORS-1:0]    sensor_error_i,
  input  logic [NUM_SENSORS-1:0]    sensor_done_i,
  output logic                      busy_o,
  output logic                      dadosPodemSerEnviados_o,
  output logic [7:0]                response_command_o,
  output logic [7:0]                response_value_o,
  output logic [7:0]                response_address_o
);

  localparam int CW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int PW = $clog2(LOOP_PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_CHECK  = 8'hAC;
  localparam logic [7:0] CMD_TEMP   = 8'h01;
  localparam logic [7:0] CMD_HUM    = 8'h02;
  localparam logic [7:0] CMD_LOOP_T = 8'h03;
  localparam logic [7:0] CMD_LOOP_H = 8'h04;
  localparam logic [7:0] CMD_STOP_T = 8'h05;
  localparam logic [7:0] CMD_STOP_H = 8'h06;

  typedef enum logic [1:0] {MODE_OFF, MODE_TEMP, MODE_HUM} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DECIDE, S_SEND, S_COOLDOWN} state_e;

  state_e        state_q, state_d;
  mode_e         mode_q [NUM_SENSORS];
  mode_e         mode_d [NUM_SENSORS];
  logic [CW-1:0] ch_q, ch_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    pend_cmd_q, pend_cmd_d;
  logic [7:0]    pend_val_q, pend_val_d;
  logic          read_q, read_d;
  logic          sched_q, sched_d;
  logic          fault_q, fault_d;
  logic [7:0]    temp_q, temp_d;
  logic [7:0]    hum_q, hum_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic          tick_pending_q, tick_pending_d;
  logic          valid_q, valid_d;
  logic [7:0]    resp_cmd_q, resp_cmd_d;
  logic [7:0]    resp_val_q, resp_val_d;
  logic [7:0]    resp_addr_q, resp_addr_d;

  logic [39:0]          chan_data [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] chan_on;
  logic [NUM_SENSORS-1:0] chan_sel;
  logic [CW-1:0]        first_on, next_on;
  logic                 next_found;
  logic                 en_phase;
  logic                 req_in_range;
  logic [CW-1:0]        req_ch;
  logic                 tick_clr;
  logic                 active_d;

  function automatic logic checksum_ok(input logic [39:0] d);
    logic [7:0] sum;
    sum = d[39:32] + d[31:24] + d[23:16] + d[15:8];
    return sum == d[7:0];
  endfunction

  // Driver enable spans ISSUE..SEND so the driver holds its data until the response is out.
  assign en_phase = read_q && (state_q == S_ISSUE || state_q == S_WAIT ||
                               state_q == S_DECIDE || state_q == S_SEND);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_chan
      assign chan_data[gi]       = sensor_data_i[40*gi +: 40];
      assign chan_on[gi]         = (mode_q[gi] != MODE_OFF);
      assign chan_sel[gi]        = (ch_q == CW'(gi));
      assign sensor_enable_o[gi] = en_phase && chan_sel[gi];
    end
  endgenerate

  assign req_in_range = ({24'd0, request_address_i} < 32'(NUM_SENSORS));
  assign req_ch       = request_address_i[CW-1:0];

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    first_on   = '0;
    next_on    = '0;
    next_found = 1'b0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (chan_on[i]) begin
        first_on = CW'(i);
        if (i > int'(ch_q)) begin
          next_on    = CW'(i);
          next_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    ch_d           = ch_q;
    addr_d         = addr_q;
    cmd_d          = cmd_q;
    pend_cmd_d     = pend_cmd_q;
    pend_val_d     = pend_val_q;
    read_d         = read_q;
    sched_d        = sched_q;
    fault_d        = fault_q;
    temp_d         = temp_q;
    hum_d          = hum_q;
    wait_cnt_d     = wait_cnt_q;
    resp_cmd_d     = resp_cmd_q;
    resp_val_d     = resp_val_q;
    resp_addr_d    = resp_addr_q;
    valid_d        = 1'b0;
    tick_clr       = 1'b0;
    period_d       = period_q;
    tick_pending_d = tick_pending_q;
    active_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          addr_d  = request_address_i;
          cmd_d   = request_command_i;
          sched_d = 1'b0;
          read_d  = 1'b0;
          state_d = S_DECIDE;
          if (!req_in_range) begin
            pend_cmd_d = 8'hFD;
            pend_val_d = 8'hFD;
          end else begin
            ch_d = req_ch;
            case (request_command_i)
              CMD_CHECK, CMD_TEMP, CMD_HUM: begin
                if (mode_q[req_ch] != MODE_OFF) begin
                  pend_cmd_d = 8'hFF;
                  pend_val_d = 8'hFF;
                end else begin
                  read_d  = 1'b1;
                  state_d = S_ISSUE;
                end
              end
              CMD_LOOP_T: begin
                mode_d[req_ch] = MODE_TEMP;
                state_d        = S_IDLE;
              end
              CMD_LOOP_H: begin
                mode_d[req_ch] = MODE_HUM;
                state_d        = S_IDLE;
              end
              CMD_STOP_T: begin
                if (mode_q[req_ch] == MODE_TEMP) begin
                  mode_d[req_ch] = MODE_OFF;
                  pend_cmd_d     = 8'h0A;
                  pend_val_d     = 8'h0A;
                end else begin
                  pend_cmd_d = 8'hAA;
                  pend_val_d = 8'hAA;
                end
              end
              CMD_STOP_H: begin
                if (mode_q[req_ch] == MODE_HUM) begin
                  mode_d[req_ch] = MODE_OFF;
                  pend_cmd_d     = 8'h0B;
                  pend_val_d     = 8'h0B;
                end else begin
                  pend_cmd_d = 8'hAA;
                  pend_val_d = 8'hAA;
                end
              end
              default: begin
                pend_cmd_d = 8'h45;
                pend_val_d = 8'h45;
              end
            endcase
          end
        end else if (tick_pending_q) begin
          ch_d    = first_on;
          addr_d  = 8'(first_on);
          sched_d = 1'b1;
          read_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (sensor_done_i[ch_q]) begin
          temp_d  = chan_data[ch_q][23:16];
          hum_d   = chan_data[ch_q][39:32];
          fault_d = sensor_error_i[ch_q] || !checksum_ok(chan_data[ch_q]);
          state_d = S_DECIDE;
        end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = S_DECIDE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_DECIDE: begin
        valid_d     = 1'b1;
        resp_addr_d = addr_q;
        state_d     = S_SEND;
        if (!read_q) begin
          resp_cmd_d = pend_cmd_q;
          resp_val_d = pend_val_q;
        end else if (fault_q) begin
          resp_cmd_d = 8'h1F;
          resp_val_d = 8'h1F;
        end else if (sched_q) begin
          if (mode_q[ch_q] == MODE_TEMP) begin
            resp_cmd_d = 8'h0D;
            resp_val_d = temp_q;
          end else begin
            resp_cmd_d = 8'h0E;
            resp_val_d = hum_q;
          end
        end else begin
          case (cmd_q)
            CMD_TEMP: begin
              resp_cmd_d = 8'h09;
              resp_val_d = temp_q;
            end
            CMD_HUM: begin
              resp_cmd_d = 8'h08;
              resp_val_d = hum_q;
            end
            default: begin
              resp_cmd_d = 8'h07;
              resp_val_d = 8'h07;
            end
          endcase
        end
      end

      S_SEND: begin
        state_d = read_q ? S_COOLDOWN : S_IDLE;
      end

      S_COOLDOWN: begin
        if (sched_q && next_found) begin
          ch_d    = next_on;
          addr_d  = 8'(next_on);
          state_d = S_ISSUE;
        end else begin
          tick_clr = sched_q;
          sched_d  = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Period counter runs only while some channel is in a continuous mode.
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (mode_d[i] != MODE_OFF) active_d = 1'b1;
    end
    if (!active_d) begin
      period_d       = '0;
      tick_pending_d = 1'b0;
    end else begin
      if (tick_clr) tick_pending_d = 1'b0;
      if (period_q == PW'(LOOP_PERIOD_CYCLES - 1)) begin
        period_d       = '0;
        tick_pending_d = 1'b1;
      end else begin
        period_d = period_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < NUM_SENSORS; i++) mode_q[i] <= MODE_OFF;
      ch_q           <= '0;
      addr_q         <= '0;
      cmd_q          <= '0;
      pend_cmd_q     <= '0;
      pend_val_q     <= '0;
      read_q         <= 1'b0;
      sched_q        <= 1'b0;
      fault_q        <= 1'b0;
      temp_q         <= '0;
      hum_q          <= '0;
      wait_cnt_q     <= '0;
      period_q       <= '0;
      tick_pending_q <= 1'b0;
      valid_q        <= 1'b0;
      resp_cmd_q     <= '0;
      resp_val_q     <= '0;
      resp_addr_q    <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      ch_q           <= ch_d;
      addr_q         <= addr_d;
      cmd_q          <= cmd_d;
      pend_cmd_q     <= pend_cmd_d;
      pend_val_q     <= pend_val_d;
      read_q         <= read_d;
      sched_q        <= sched_d;
      fault_q        <= fault_d;
      temp_q         <= temp_d;
      hum_q          <= hum_d;
      wait_cnt_q     <= wait_cnt_d;
      period_q       <= period_d;
      tick_pending_q <= tick_pending_d;
      valid_q        <= valid_d;
      resp_cmd_q     <= resp_cmd_d;
      resp_val_q     <= resp_val_d;
      resp_addr_q    <= resp_addr_d;
    end
  end

  assign busy_o                  = (state_q != S_IDLE);
  assign dadosPodemSerEnviados_o = valid_q;
  assign response_command_o      = resp_cmd_q;
  assign response_value_o        = resp_val_q;
  assign response_address_o      = resp_addr_q;

endmodule

// File: tb/tb_sensor_hub.sv
// Directed bench for sensor_hub: behavioural sensor drivers plus an in-order
// response scoreboard fed as each request is issued.
module tb_sensor_hub;

  localparam int NS   = 4;
  localparam int LOOP = 1000;
  localparam int TO   = 50;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [7:0]      cmd;
  logic [7:0]      addr;
  logic [NS-1:0]   sen_en;
  logic [40*NS-1:0] sen_data;
  logic [NS-1:0]   sen_err;
  logic [NS-1:0]   sen_done;
  logic            busy;
  logic            valid;
  logic [7:0]      rcmd;
  logic [7:0]      rval;
  logic [7:0]      raddr;

  sensor_hub #(
    .NUM_SENSORS(NS),
    .LOOP_PERIOD_CYCLES(LOOP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_i(clk),
    .reset_n_i(rst_n),
    .enable_i(enable),
    .request_command_i(cmd),
    .request_address_i(addr),
    .sensor_enable_o(sen_en),
    .sensor_data_i(sen_data),
    .sensor_error_i(sen_err),
    .sensor_done_i(sen_done),
    .busy_o(busy),
    .dadosPodemSerEnviados_o(valid),
    .response_command_o(rcmd),
    .response_value_o(rval),
    .response_address_o(raddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] v;
    logic [7:0] a;
  } resp_t;

  resp_t sb_q[$];
  resp_t mon_e;
  int    checks     = 0;
  int    failures   = 0;
  int    resp_count = 0;
  int    exp_count  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] v, input logic [7:0] a);
    sb_q.push_back({c, v, a});
    exp_count++;
  endtask

  // Response monitor: every valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      resp_count++;
      if (sb_q.size() == 0) begin
        check("resp_unexpected", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        $display("RESP cmd=%02h val=%02h addr=%02h (exp %02h/%02h/%02h)",
                 rcmd, rval, raddr, mon_e.c, mon_e.v, mon_e.a);
        check("resp_cmd", 32'(rcmd), 32'(mon_e.c));
        check("resp_val", 32'(rval), 32'(mon_e.v));
        check("resp_addr", 32'(raddr), 32'(mon_e.a));
      end
    end
  end

  // Sensor drivers: done pulses for one cycle a few cycles after enable rises.
  int            drv_cnt [NS];
  logic [NS-1:0] drv_fired = '0;
  logic [NS-1:0] noresp;
  initial sen_done = '0;
  always @(negedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (sen_en[k] && !drv_fired[k]) begin
        if (drv_cnt[k] == 3) begin
          sen_done[k]  = !noresp[k];
          drv_fired[k] = 1'b1;
        end else begin
          drv_cnt[k] = drv_cnt[k] + 1;
        end
      end else begin
        sen_done[k] = 1'b0;
        if (!sen_en[k]) begin
          drv_fired[k] = 1'b0;
          drv_cnt[k]   = 0;
        end
      end
    end
  end

  task automatic set_ch(input int k, input logic [39:0] d);
    sen_data[40*k +: 40] = d;
  endtask

  task automatic send_req(input logic [7:0] c, input logic [7:0] a);
    @(negedge clk);
    enable = 1'b1;
    cmd    = c;
    addr   = a;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < NS; k++) drv_cnt[k] = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    cmd      = '0;
    addr     = '0;
    sen_data = '0;
    sen_err  = '0;
    noresp   = 4'b0010;
    repeat (3) @(negedge clk);
    check("rst_sensor_enable", 32'(sen_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_resp_cmd", 32'(rcmd), 32'd0);
    check("rst_resp_val", 32'(rval), 32'd0);
    check("rst_resp_addr", 32'(raddr), 32'd0);
    rst_n = 1'b1;
    set_ch(0, 40'h37_00_19_00_50);
    set_ch(1, 40'h11_00_22_00_33);
    set_ch(2, 40'h37_00_19_00_51);
    set_ch(3, 40'h41_02_15_03_5B);

    // Temperature read on ch0 with cycle-accurate handshake checks
    push(8'h09, 8'h19, 8'h00);
    send_req(8'h01, 8'h00);
    check("read_busy_t1", 32'(busy), 32'd1);
    check("read_enable_t1", 32'(sen_en), 32'b0001);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sen_done[0] !== 1'b1 && n < 50);
    check("done_seen", 32'(sen_done[0]), 32'd1);
    @(negedge clk);
    check("valid_d1", 32'(valid), 32'd0);
    @(negedge clk);
    check("valid_d2", 32'(valid), 32'd1);
    @(negedge clk);
    check("cooldown_enable", 32'(sen_en), 32'd0);
    check("cooldown_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("idle_d4", 32'(busy), 32'd0);

    push(8'h08, 8'h37, 8'h00);
    send_req(8'h02, 8'h00);
    wait_drain(100, "drain_hum0");

    // Checksum fault, good presence check, driver error
    push(8'h1F, 8'h1F, 8'h02);
    send_req(8'hAC, 8'h02);
    wait_drain(100, "drain_badsum");
    push(8'h07, 8'h07, 8'h00);
    send_req(8'hAC, 8'h00);
    wait_drain(100, "drain_check0");
    sen_err = 4'b1000;
    push(8'h1F, 8'h1F, 8'h03);
    send_req(8'h01, 8'h03);
    wait_drain(100, "drain_err3");
    sen_err = '0;

    // Timeout on ch1, which never signals done
    push(8'h1F, 8'h1F, 8'h01);
    send_req(8'hAC, 8'h01);
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'(TO + 2));
    wait_idle("idle_timeout");

    // Out-of-range address and unknown command
    push(8'hFD, 8'hFD, 8'h07);
    send_req(8'h01, 8'h07);
    check("range_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("range_valid_t2", 32'(valid), 32'd1);
    wait_idle("idle_range");
    push(8'h45, 8'h45, 8'h00);
    send_req(8'h77, 8'h00);
    wait_drain(50, "drain_unknown");

    // Strobe while busy is dropped
    push(8'h08, 8'h37, 8'h00);
    send_req(8'h02, 8'h00);
    enable = 1'b1;
    cmd    = 8'h77;
    addr   = 8'h00;
    @(negedge clk);
    enable = 1'b0;
    wait_idle("idle_drop");
    repeat (5) @(negedge clk);
    check("drop_resp_count", 32'(resp_count), 32'(exp_count));

    // Continuous modes: ch0 TEMP, ch3 HUM
    send_req(8'h03, 8'h00);
    check("loop_t_nobusy", 32'(busy), 32'd0);
    send_req(8'h04, 8'h03);
    check("loop_h_nobusy", 32'(busy), 32'd0);
    push(8'h0D, 8'h19, 8'h00);
    push(8'h0E, 8'h41, 8'h03);
    wait_drain(1500, "drain_period1");

    // Host request A spans the next tick; B is held so it is ready on return to IDLE
    repeat (960) @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    cmd    = 8'hAC;
    addr   = 8'h01;
    push(8'h1F, 8'h1F, 8'h01);
    @(negedge clk);
    check("a_accepted", 32'(busy), 32'd1);
    cmd  = 8'h77;
    addr = 8'h00;
    push(8'h45, 8'h45, 8'h00);
    push(8'h0D, 8'h19, 8'h00);
    push(8'h0E, 8'h41, 8'h03);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_finished", 32'(busy), 32'd0);
    @(negedge clk);
    enable = 1'b0;
    check("b_accepted", 32'(busy), 32'd1);
    wait_drain(300, "drain_priority");
    wait_idle("idle_priority");

    // Reads refused while a channel is in a continuous mode; stop commands
    push(8'hFF, 8'hFF, 8'h00);
    send_req(8'h01, 8'h00);
    wait_drain(50, "drain_ff");
    push(8'h0A, 8'h0A, 8'h00);
    send_req(8'h05, 8'h00);
    wait_drain(50, "drain_stop_t");
    push(8'hAA, 8'hAA, 8'h00);
    send_req(8'h05, 8'h00);
    wait_drain(50, "drain_stop_t_again");
    push(8'h0B, 8'h0B, 8'h03);
    send_req(8'h06, 8'h03);
    wait_drain(50, "drain_stop_h");
    push(8'hAA, 8'hAA, 8'h03);
    send_req(8'h06, 8'h03);
    wait_drain(50, "drain_stop_h_again");
    repeat (2500) @(negedge clk);
    check("quiet_after_stop", 32'(resp_count), 32'(exp_count));

    // Reset while waiting on ch1 aborts the transaction and clears modes
    send_req(8'h03, 8'h00);
    send_req(8'hAC, 8'h01);
    repeat (10) @(negedge clk);
    check("wait_enable", 32'(sen_en), 32'b0010);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_enable", 32'(sen_en), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2500) @(negedge clk);
    check("quiet_after_reset", 32'(resp_count), 32'(exp_count));
    push(8'hAA, 8'hAA, 8'h00);
    send_req(8'h05, 8'h00);
    wait_drain(50, "drain_mode_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
